// File: rtl/dmd_scan_driver.sv
// rtl/dmd_scan_driver.sv - dot-matrix scan driver: column frame buffer, 16-position window scan, optional scroll
module dmd_scan_driver #(
  parameter int COLUMNS       = 32,
  parameter int DWELL         = 8,
  parameter int SCROLL_FRAMES = 4
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       wr_en,
  input  logic [$clog2(COLUMNS)-1:0] wr_addr,
  input  logic [15:0]                wr_data,
  input  logic                       enable,
  input  logic                       scroll_en,
  output logic [3:0]                 column_seg,
  output logic [15:0]                out_column,
  output logic                       COLUMN_CLK,
  output logic                       OUT_CLR,
  output logic [$clog2(COLUMNS)-1:0] base,
  output logic                       frame_done
);

  localparam int AW  = $clog2(COLUMNS);
  localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int FCW = $clog2(SCROLL_FRAMES + 1);

  typedef enum logic [1:0] {S_BLANK, S_LATCH, S_STROBE, S_DWELL} state_t;

  state_t           state, state_nxt;
  logic [15:0]      mem [COLUMNS];
  logic [DCW-1:0]   dwell_cnt;
  logic [FCW-1:0]   frame_cnt;
  logic [AW-1:0]    rd_addr;
  logic             last_dwell;
  logic             frame_end;

  assign rd_addr    = base + AW'(column_seg);
  assign last_dwell = (state == S_DWELL) && (dwell_cnt == DCW'(DWELL - 1));
  assign frame_end  = last_dwell && (column_seg == 4'hF);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= S_BLANK;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_BLANK:  if (enable) state_nxt = S_LATCH;
      S_LATCH:  state_nxt = S_STROBE;
      S_STROBE: state_nxt = S_DWELL;
      S_DWELL:  if (last_dwell) state_nxt = S_BLANK;
      default:  state_nxt = S_BLANK;
    endcase
  end

  always_comb begin
    OUT_CLR    = (state != S_DWELL);
    COLUMN_CLK = (state == S_STROBE);
  end

  // Reads happen at the same edge as writes, so a colliding write is seen only next frame.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < COLUMNS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      dwell_cnt  <= '0;
      column_seg <= '0;
      out_column <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (state == S_DWELL) dwell_cnt <= last_dwell ? '0 : dwell_cnt + DCW'(1);
      else                  dwell_cnt <= '0;
      if (state == S_LATCH) out_column <= mem[rd_addr];
      if (last_dwell)       column_seg <= column_seg + 4'd1;
    end
  end

  // Window base moves only on a frame boundary; disabling scroll discards partial frame counts.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      frame_cnt <= '0;
      base      <= '0;
    end else if (!scroll_en) begin
      frame_cnt <= '0;
    end else if (frame_end) begin
      if (frame_cnt == FCW'(SCROLL_FRAMES - 1)) begin
        frame_cnt <= '0;
        base      <= base + AW'(1);
      end else begin
        frame_cnt <= frame_cnt + FCW'(1);
      end
    end
  end

endmodule

// File: tb/tb_dmd_scan_driver.sv
// tb/tb_dmd_scan_driver.sv - scoreboard bench for dmd_scan_driver with frame-level reference model
module tb_dmd_scan_driver;
  localparam int COLUMNS = 32;
  localparam int DWELL   = 8;
  localparam int SF      = 4;
  localparam int POS     = 3 + DWELL;
  localparam int FRAME   = 16 * POS;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        enable = 1'b0;
  logic        scroll_en = 1'b0;
  logic [3:0]  column_seg;
  logic [15:0] out_column;
  logic        COLUMN_CLK;
  logic        OUT_CLR;
  logic [4:0]  base;
  logic        frame_done;

  dmd_scan_driver #(.COLUMNS(COLUMNS), .DWELL(DWELL), .SCROLL_FRAMES(SF)) dut (
    .CLK(CLK), .RESET(RESET), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .enable(enable), .scroll_en(scroll_en), .column_seg(column_seg), .out_column(out_column),
    .COLUMN_CLK(COLUMN_CLK), .OUT_CLR(OUT_CLR), .base(base), .frame_done(frame_done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  seg;
    logic [15:0] data;
    logic [4:0]  base;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] mbuf [COLUMNS];
  int          mbase = 0;
  int          mcnt = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One frame = 16 strobes showing words base..base+15 (mod COLUMNS); scroll bookkeeping at frame end.
  task automatic push_frames(int n);
    exp_t e;
    for (int f = 0; f < n; f++) begin
      for (int s = 0; s < 16; s++) begin
        e.seg  = 4'(s);
        e.data = mbuf[(mbase + s) % COLUMNS];
        e.base = 5'(mbase);
        q.push_back(e);
      end
      if (scroll_en) begin
        mcnt++;
        if (mcnt == SF) begin
          mbase = (mbase + 1) % COLUMNS;
          mcnt  = 0;
        end
      end else begin
        mcnt = 0;
      end
    end
  endtask

  task automatic wr_word(int a, logic [15:0] d);
    @(negedge CLK);
    wr_en = 1'b1; wr_addr = 5'(a); wr_data = d;
    @(negedge CLK);
    wr_en = 1'b0;
    mbuf[a] = d;
  endtask

  task automatic wait_frames(int n);
    int seen = 0;
    int cyc = 0;
    enable = 1'b1;
    while (seen < n && cyc < n * FRAME + 4 * POS) begin
      @(negedge CLK);
      cyc++;
      if (frame_done) seen++;
    end
    enable = 1'b0;
    check("frames_seen", seen, n);
  endtask

  task automatic run_frames(int n);
    push_frames(n);
    wait_frames(n);
    check("queue_drained", q.size(), 0);
  endtask

  // Monitor: pops the scoreboard on every strobe, and checks timing while scanning is uninterrupted.
  initial begin
    exp_t e;
    int   cyc = 0, run = 0, last_s = 0, last_f = 0;
    bit   hs = 0, hf = 0, bs = 1, bf = 1;
    forever begin
      @(negedge CLK);
      cyc++;
      if (!RESET) begin
        if (COLUMN_CLK) begin
          check("strobe_blanked", OUT_CLR, 1'b1);
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: seg %0d data %0h with empty scoreboard", column_seg, out_column);
          end else begin
            e = q.pop_front();
            check("seg", column_seg, e.seg);
            check("out_column", out_column, e.data);
            check("base", base, e.base);
          end
          if (hs && !bs) check("strobe_period", cyc - last_s, POS);
          hs = 1; bs = 0; last_s = cyc;
        end
        if (frame_done) begin
          if (hf && !bf) check("frame_period", cyc - last_f, FRAME);
          hf = 1; bf = 0; last_f = cyc;
        end
        if (!OUT_CLR) run++;
        else if (run != 0) begin
          check("dwell_len", run, DWELL);
          run = 0;
        end
      end
      if (!enable || RESET) begin
        bs = 1; bf = 1;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, ns, c, strobes, lit;
    for (int i = 0; i < COLUMNS; i++) mbuf[i] = '0;
    #2 RESET = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_seg", column_seg, 0);
    check("rst_out_column", out_column, 0);
    check("rst_column_clk", COLUMN_CLK, 0);
    check("rst_out_clr", OUT_CLR, 1);
    check("rst_base", base, 0);
    check("rst_frame_done", frame_done, 0);
    RESET = 1'b0;

    scroll_en = 1'b0;
    run_frames(2);

    for (int k = 0; k < 16; k++) wr_word(k, 16'h0001 << k);
    run_frames(1);

    wr_word(31, 16'hBEEF);
    wr_word(0, 16'h1234);
    scroll_en = 1'b1;
    run_frames(125);
    check("scroll_base", base, mbase);

    // Collision: write the word of seg 5 during its LATCH cycle.
    scroll_en = 1'b0;
    a = (mbase + 5) % COLUMNS;
    wr_word(a, 16'h5555);
    push_frames(1);
    mbuf[a] = 16'hAAAA;
    push_frames(1);
    enable = 1'b1;
    repeat (1 + 11 * 5) @(posedge CLK);
    #1;
    check("latch_seg", column_seg, 5);
    check("latch_blanked", OUT_CLR, 1);
    check("latch_no_strobe", COLUMN_CLK, 0);
    wr_en = 1'b1; wr_addr = 5'(a); wr_data = 16'hAAAA;
    @(posedge CLK);
    #1 wr_en = 1'b0;
    wait_frames(2);
    check("queue_drained", q.size(), 0);

    // Drop enable in seg 7 dwell; park blanked at seg 8, then resume.
    push_frames(1);
    enable = 1'b1;
    repeat (1 + 11 * 7 + 4) @(posedge CLK);
    #1;
    check("park_seg7", column_seg, 7);
    check("park_lit", OUT_CLR, 0);
    enable = 1'b0;
    repeat (10) @(negedge CLK);
    strobes = 0; lit = 0;
    repeat (20) begin
      @(negedge CLK);
      if (COLUMN_CLK) strobes++;
      if (!OUT_CLR) lit++;
    end
    check("park_strobes", strobes, 0);
    check("park_lit_cycles", lit, 0);
    check("park_seg8", column_seg, 8);
    check("park_out_clr", OUT_CLR, 1);
    wait_frames(1);
    check("queue_drained", q.size(), 0);

    for (int p = 0; p < 6; p++) begin
      int nw;
      nw = $urandom_range(1, 8);
      for (int w = 0; w < nw; w++) wr_word($urandom_range(0, COLUMNS - 1), 16'($urandom));
      scroll_en = 1'($urandom_range(0, 1));
      run_frames($urandom_range(1, 3));
    end

    // Reset during STROBE must take effect without a clock edge.
    push_frames(1);
    enable = 1'b1;
    ns = 0; c = 0;
    while (ns < 3 && c < 4 * POS) begin
      @(negedge CLK);
      c++;
      if (COLUMN_CLK) ns++;
    end
    check("reset_strobe_found", ns, 3);
    #1 RESET = 1'b1;
    #1;
    check("async_column_clk", COLUMN_CLK, 0);
    check("async_out_clr", OUT_CLR, 1);
    check("async_seg", column_seg, 0);
    check("async_base", base, 0);
    check("async_out_column", out_column, 0);
    enable = 1'b0;
    q.delete();
    for (int i = 0; i < COLUMNS; i++) mbuf[i] = '0;
    mbase = 0;
    mcnt = 0;
    @(negedge CLK);
    RESET = 1'b0;
    scroll_en = 1'b0;
    run_frames(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
